// File: rtl/sram_bist_pkg.sv
// Shared types and defaults for the SRAM march-style BIST controller.
package sram_bist_pkg;

    localparam int unsigned ERR_CNT_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sram_bist.sv
// SRAM BIST: write pattern^addr to every word, read back and count mismatches.
// Optional first-failure log enabled by defining SRAM_BIST_ERRLOG_EN.
module sram_bist
    import sram_bist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned NUM_WORDS     = 1024,
    parameter int unsigned ERR_CNT_WIDTH = ERR_CNT_WIDTH_DEF,
    localparam int unsigned ADDR_WIDTH   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [DATA_WIDTH-1:0]    pattern_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
    output logic                     sram_req_o,
    output logic                     sram_we_o,
    output logic [ADDR_WIDTH-1:0]    sram_addr_o,
    output logic [DATA_WIDTH-1:0]    sram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]  sram_be_o,
`ifdef SRAM_BIST_ERRLOG_EN
    output logic [ADDR_WIDTH-1:0]    fail_addr_o,
    output logic [DATA_WIDTH-1:0]    fail_data_o,
`endif
    input  logic [DATA_WIDTH-1:0]    sram_rdata_i
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    pattern_q, pattern_d;
    logic                     cmp_vld_q, cmp_vld_d;
    logic [DATA_WIDTH-1:0]    exp_q, exp_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
    logic                     pass_q, pass_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     req_q, req_d;
    logic                     we_q, we_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]      be_q, be_d;
    logic                     mismatch_c;
`ifdef SRAM_BIST_ERRLOG_EN
    logic [ADDR_WIDTH-1:0]    cmp_addr_q, cmp_addr_d;
    logic [ADDR_WIDTH-1:0]    fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0]    fail_data_q, fail_data_d;
`endif

    // Next state; bus outputs are registered from the next-state values so they
    // appear in the same cycle as the state they belong to.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pattern_d = pattern_q;
        err_d     = err_q;
        pass_d    = pass_q;
        cmp_vld_d = (state_q == ST_READ);
        exp_d     = pattern_q ^ DATA_WIDTH'(addr_q);

        mismatch_c = cmp_vld_q && (sram_rdata_i != exp_q);
        if (mismatch_c && (err_q != '1)) begin
            err_d = err_q + ERR_CNT_WIDTH'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_WRITE;
                    addr_d    = '0;
                    pattern_d = pattern_i;
                    err_d     = '0;
                    pass_d    = 1'b0;
                end
            end
            ST_WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_READ: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                pass_d  = (err_d == '0);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        req_d   = (state_d == ST_WRITE) || (state_d == ST_READ);
        we_d    = (state_d == ST_WRITE);
        be_d    = we_d ? '1 : '0;
        wdata_d = we_d ? (pattern_d ^ DATA_WIDTH'(addr_d)) : '0;

`ifdef SRAM_BIST_ERRLOG_EN
        cmp_addr_d  = addr_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        if (mismatch_c && (err_q == '0)) begin
            fail_addr_d = cmp_addr_q;
            fail_data_d = sram_rdata_i;
        end
        if ((state_q == ST_IDLE) && start_i) begin
            fail_addr_d = '0;
            fail_data_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            pattern_q <= '0;
            cmp_vld_q <= 1'b0;
            exp_q     <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pattern_q <= pattern_d;
            cmp_vld_q <= cmp_vld_d;
            exp_q     <= exp_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            req_q     <= req_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
        end
    end

`ifdef SRAM_BIST_ERRLOG_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmp_addr_q  <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            cmp_addr_q  <= cmp_addr_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;
`endif

    // Address counter idles at zero, so it doubles as the gated SRAM address.
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_cnt_o    = err_q;
    assign sram_req_o   = req_q;
    assign sram_we_o    = we_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;
    assign sram_be_o    = be_q;

endmodule

// File: tb/tb_sram_bist.sv
// Randomized self-checking bench for sram_bist with behavioural SRAM models.
`timescale 1ns/1ps
module tb_sram_bist;

    localparam int unsigned DW  = 64;
    localparam int unsigned NA  = 16;
    localparam int unsigned NB  = 32;
    localparam int unsigned EWB = 4;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: 16 words, fault-injecting SRAM ----------------
    logic          start_a, busy_a, done_a, pass_a, req_a, we_a;
    logic [DW-1:0] pattern_a, wdata_a, rdata_a;
    logic [15:0]   err_a;
    logic [3:0]    addr_a;
    logic [7:0]    be_a;
`ifdef SRAM_BIST_ERRLOG_EN
    logic [3:0]    faddr_a;
    logic [DW-1:0] fdata_a;
`endif

    sram_bist #(.DATA_WIDTH(DW), .NUM_WORDS(NA), .ERR_CNT_WIDTH(16)) u_dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_a), .pattern_i(pattern_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_cnt_o(err_a),
        .sram_req_o(req_a), .sram_we_o(we_a), .sram_addr_o(addr_a),
        .sram_wdata_o(wdata_a), .sram_be_o(be_a),
`ifdef SRAM_BIST_ERRLOG_EN
        .fail_addr_o(faddr_a), .fail_data_o(fdata_a),
`endif
        .sram_rdata_i(rdata_a));

    logic [DW-1:0] mem_a  [NA];
    logic [DW-1:0] flip_a [NA];
    int wr_a = 0, rd_a = 0, idle_a = 0;

    always @(posedge clk_i) begin
        if (req_a) begin
            if (we_a) begin
                for (int b = 0; b < DW/8; b++)
                    if (be_a[b]) mem_a[addr_a][8*b +: 8] <= wdata_a[8*b +: 8];
                wr_a++;
            end else begin
                rdata_a <= mem_a[addr_a] ^ flip_a[addr_a];
                rd_a++;
            end
        end else if (addr_a != '0 || wdata_a != '0 || we_a) begin
            idle_a++;
        end
    end

    // ---------------- instance B: 32 words, 4-bit counter, read data stuck at 0 ----------------
    logic          start_b, busy_b, done_b, pass_b, req_b, we_b;
    logic [DW-1:0] pattern_b, wdata_b;
    logic [DW-1:0] rdata_b;
    logic [EWB-1:0] err_b;
    logic [4:0]    addr_b;
    logic [7:0]    be_b;
`ifdef SRAM_BIST_ERRLOG_EN
    logic [4:0]    faddr_b;
    logic [DW-1:0] fdata_b;
`endif
    assign rdata_b = '0;

    sram_bist #(.DATA_WIDTH(DW), .NUM_WORDS(NB), .ERR_CNT_WIDTH(EWB)) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_b), .pattern_i(pattern_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_cnt_o(err_b),
        .sram_req_o(req_b), .sram_we_o(we_b), .sram_addr_o(addr_b),
        .sram_wdata_o(wdata_b), .sram_be_o(be_b),
`ifdef SRAM_BIST_ERRLOG_EN
        .fail_addr_o(faddr_b), .fail_data_o(fdata_b),
`endif
        .sram_rdata_i(rdata_b));

    // ---------------- instance C: single word ----------------
    logic          start_c, busy_c, done_c, pass_c, req_c, we_c;
    logic [DW-1:0] pattern_c, wdata_c, rdata_c, mem_c;
    logic [15:0]   err_c;
    logic [0:0]    addr_c;
    logic [7:0]    be_c;
`ifdef SRAM_BIST_ERRLOG_EN
    logic [0:0]    faddr_c;
    logic [DW-1:0] fdata_c;
`endif

    sram_bist #(.DATA_WIDTH(DW), .NUM_WORDS(1), .ERR_CNT_WIDTH(16)) u_dut_c (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_c), .pattern_i(pattern_c),
        .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c), .err_cnt_o(err_c),
        .sram_req_o(req_c), .sram_we_o(we_c), .sram_addr_o(addr_c),
        .sram_wdata_o(wdata_c), .sram_be_o(be_c),
`ifdef SRAM_BIST_ERRLOG_EN
        .fail_addr_o(faddr_c), .fail_data_o(fdata_c),
`endif
        .sram_rdata_i(rdata_c));

    always @(posedge clk_i) begin
        if (req_c) begin
            if (we_c) mem_c <= wdata_c;
            else      rdata_c <= mem_c;
        end
    end

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = {$urandom(), $urandom()};
        return w;
    endfunction

    // One run on A; expectations come from the injected fault map.
    task automatic run_a(input string tag, input logic [DW-1:0] pat, input int restart_at);
        int cyc, done_at, n_done, busy_bad, exp_err, first, w0, r0, i0, mem_bad;
        exp_err = 0;
        first   = -1;
        for (int a = 0; a < NA; a++) begin
            if (flip_a[a] != '0) begin
                exp_err++;
                if (first < 0) first = a;
            end
        end
        w0 = wr_a; r0 = rd_a; i0 = idle_a;
        @(negedge clk_i);
        pattern_a = pat;
        start_a   = 1'b1;
        @(posedge clk_i); #1;
        start_a   = 1'b0;
        pattern_a = ~pat;
        cyc = 1; done_at = 0; n_done = 0; busy_bad = 0;
        while (cyc <= 60) begin
            if (done_a) begin
                n_done++;
                if (done_at == 0) done_at = cyc;
            end
            if (busy_a != (cyc <= 2*NA+2)) busy_bad++;
            start_a = (cyc == restart_at);
            if (start_a) pattern_a = rand_word();
            @(posedge clk_i); #1;
            cyc++;
        end
        start_a = 1'b0;
        mem_bad = 0;
        for (int a = 0; a < NA; a++)
            if (mem_a[a] !== (pat ^ DW'(a))) mem_bad++;
        check({tag, ":done_cycle"}, 64'(done_at), 64'(2*NA+2));
        check({tag, ":done_pulses"}, 64'(n_done), 64'd1);
        check({tag, ":busy_window"}, 64'(busy_bad), 64'd0);
        check({tag, ":err_cnt"}, 64'(err_a), 64'(exp_err));
        check({tag, ":pass"}, 64'(pass_a), 64'(exp_err == 0));
        check({tag, ":writes"}, 64'(wr_a - w0), 64'(NA));
        check({tag, ":reads"}, 64'(rd_a - r0), 64'(NA));
        check({tag, ":idle_bus"}, 64'(idle_a - i0), 64'd0);
        check({tag, ":mem_content"}, 64'(mem_bad), 64'd0);
`ifdef SRAM_BIST_ERRLOG_EN
        check({tag, ":fail_addr"}, 64'(faddr_a), (first < 0) ? 64'd0 : 64'(first));
        check({tag, ":fail_data"}, fdata_a,
              (first < 0) ? 64'd0 : (pat ^ DW'(first) ^ flip_a[first]));
`endif
    endtask

    initial begin
        int cyc, done_at, nd, nf, a;
        logic [DW-1:0] pat;
        rst_ni = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        pattern_a = '0; pattern_b = '1; pattern_c = '0;
        for (int i = 0; i < NA; i++) flip_a[i] = '0;
        #12;
        check("reset:busy", 64'(busy_a), 64'd0);
        check("reset:pass", 64'(pass_a), 64'd0);
        check("reset:err", 64'(err_a), 64'd0);
        check("reset:req", 64'(req_a), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_a("clean_a5", 64'hA5A5_A5A5_A5A5_A5A5, 0);
        flip_a[5] = 64'h1;
        run_a("flip_addr5", 64'hA5A5_A5A5_A5A5_A5A5, 0);
        flip_a[5] = '0;
        run_a("restart_in_read", rand_word(), 20);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NA; i++) flip_a[i] = '0;
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                a = $urandom_range(0, NA-1);
                flip_a[a] = rand_word() | 64'h1;
            end
            run_a($sformatf("rand%0d", r), rand_word(), 0);
        end
        for (int i = 0; i < NA; i++) flip_a[i] = '0;

        // Abort mid-write: reset must clear outputs without waiting for a clock.
        @(negedge clk_i);
        pattern_a = rand_word();
        start_a   = 1'b1;
        @(posedge clk_i); #1;
        start_a = 1'b0;
        cyc = 1;
        while (cyc < 8) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        check("abort:addr_before", 64'(addr_a), 64'd7);
        #2 rst_ni = 1'b0;
        #1;
        check("abort:busy", 64'(busy_a), 64'd0);
        check("abort:req_we", 64'({req_a, we_a}), 64'd0);
        check("abort:addr", 64'(addr_a), 64'd0);
        check("abort:wdata", wdata_a, 64'd0);
        check("abort:be_done_pass", 64'({be_a, done_a, pass_a}), 64'd0);
        check("abort:err", 64'(err_a), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        nd = 0;
        repeat (60) begin
            @(posedge clk_i); #1;
            if (done_a || busy_a) nd++;
        end
        check("abort:no_done", 64'(nd), 64'd0);
        run_a("after_abort", rand_word(), 0);

        // Saturating counter: every compare fails.
        @(negedge clk_i);
        pattern_b = '1;
        start_b   = 1'b1;
        @(posedge clk_i); #1;
        start_b = 1'b0;
        cyc = 1; done_at = 0;
        while (cyc <= 200 && done_at == 0) begin
            if (done_b) done_at = cyc;
            else begin
                @(posedge clk_i); #1;
                cyc++;
            end
        end
        check("sat:done_cycle", 64'(done_at), 64'(2*NB+2));
        check("sat:err_cnt", 64'(err_b), 64'd15);
        check("sat:pass", 64'(pass_b), 64'd0);

        // Single-word memory.
        pat = rand_word();
        @(negedge clk_i);
        pattern_c = pat;
        start_c   = 1'b1;
        @(posedge clk_i); #1;
        start_c = 1'b0;
        cyc = 1; done_at = 0;
        while (cyc <= 50 && done_at == 0) begin
            if (done_c) done_at = cyc;
            else begin
                @(posedge clk_i); #1;
                cyc++;
            end
        end
        check("one:done_cycle", 64'(done_at), 64'd4);
        check("one:pass", 64'(pass_c), 64'd1);
        check("one:err_cnt", 64'(err_c), 64'd0);
        check("one:mem", mem_c, pat);
        @(posedge clk_i); #1;
        check("one:done_width", 64'({done_c, busy_c}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
